rsa_host_if: RTL and testbench

RSA_HOST_IF -- requirements
Module: rsa_host_if

---
 rtl/rsa_host_if.sv | 241 ++++++++++++++++++++++++
 tb/tb_rsa_host_if.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_host_if.sv
// rsa_host_if
// Byte-serial host front end for a modular exponentiator. The host streams
// three W-bit operands (N, e, M), MSB byte first. The block then pulses
// me_start, waits for the exponentiator to finish and streams the W-bit
// result back, MSB byte first. When key_keep is high on the last result
// byte, N and e are kept and the next job loads only a new M.
//
// Ports
//   clk        system clock, all state changes on its rising edge
//   rst        asynchronous active-low reset
//   in_valid   host byte valid
//   in_data    host byte
//   in_ready   a byte is accepted this cycle (high in the three load states)
//   key_keep   sampled on the last result byte: 1 = keep N and e
//   out_valid  result byte valid
//   out_data   result byte
//   out_ready  host takes the result byte
//   me_start   one-cycle start pulse to the exponentiator
//   me_N       modulus to the exponentiator
//   me_e       exponent to the exponentiator
//   me_M       message to the exponentiator
//   me_ready   exponentiator done level (also high while it is idle)
//   me_A1      exponentiator result
//   busy       high in every state except LOAD_N
module rsa_host_if #(
    parameter int NBYTES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  key_keep,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    input  logic                  out_ready,
    output logic                  me_start,
    output logic [8*NBYTES-1:0]   me_N,
    output logic [8*NBYTES-1:0]   me_e,
    output logic [8*NBYTES-1:0]   me_M,
    input  logic                  me_ready,
    input  logic [8*NBYTES-1:0]   me_A1,
    output logic                  busy
);

    localparam int W  = 8 * NBYTES;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_LOAD_N = 3'd0,
        S_LOAD_E = 3'd1,
        S_LOAD_M = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4,
        S_SEND   = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic            r_armed;
    logic [W-1:0]    r_n;
    logic [W-1:0]    r_e;
    logic [W-1:0]    r_m;
    logic [W-1:0]    r_result;

    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_cnt_last;
    logic            w_done;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_cnt_last = (r_cnt == CNT_LAST);
    // me_ready is high while the exponentiator is idle, so it only means
    // "done" once it has been observed low during this job.
    assign w_done     = r_armed & me_ready;

    assign me_N = r_n;
    assign me_e = r_e;
    assign me_M = r_m;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_LOAD_N;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD_N: begin
                if (w_in_fire && w_cnt_last) begin
                    w_state_nxt = S_LOAD_E;
                end else begin
                    w_state_nxt = S_LOAD_N;
                end
            end
            S_LOAD_E: begin
                if (w_in_fire && w_cnt_last) begin
                    w_state_nxt = S_LOAD_M;
                end else begin
                    w_state_nxt = S_LOAD_E;
                end
            end
            S_LOAD_M: begin
                if (w_in_fire && w_cnt_last) begin
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_LOAD_M;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_done) begin
                    w_state_nxt = S_SEND;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_SEND: begin
                if (w_out_fire && w_cnt_last) begin
                    w_state_nxt = key_keep ? S_LOAD_M : S_LOAD_N;
                end else begin
                    w_state_nxt = S_SEND;
                end
            end
            default: begin
                w_state_nxt = S_LOAD_N;
            end
        endcase
    end

    // Output decode from the state and result registers.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        me_start  = 1'b0;
        busy      = 1'b1;
        out_data  = r_result[W-1 -: 8];
        case (r_state)
            S_LOAD_N: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_LOAD_E: begin
                in_ready = 1'b1;
            end
            S_LOAD_M: begin
                in_ready = 1'b1;
            end
            S_START: begin
                me_start = 1'b1;
            end
            S_WAIT: begin
                in_ready = 1'b0;
            end
            S_SEND: begin
                out_valid = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Byte counter shared by the load and send phases; wraps after the last byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= {CW{1'b0}};
        end else if (w_in_fire || w_out_fire) begin
            if (w_cnt_last) begin
                r_cnt <= {CW{1'b0}};
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Done-qualifier: cleared in START, set once me_ready is seen low in WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_armed <= 1'b0;
        end else if (r_state == S_START) begin
            r_armed <= 1'b0;
        end else if (r_state == S_WAIT && !me_ready) begin
            r_armed <= 1'b1;
        end else if (r_state == S_WAIT && w_done) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= r_armed;
        end
    end

    // Operand shift registers; each one moves only in its own load state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n <= {W{1'b0}};
            r_e <= {W{1'b0}};
            r_m <= {W{1'b0}};
        end else if (w_in_fire) begin
            case (r_state)
                S_LOAD_N: r_n <= {r_n[W-9:0], in_data};
                S_LOAD_E: r_e <= {r_e[W-9:0], in_data};
                S_LOAD_M: r_m <= {r_m[W-9:0], in_data};
                default: begin
                    r_n <= r_n;
                    r_e <= r_e;
                    r_m <= r_m;
                end
            endcase
        end else begin
            r_n <= r_n;
            r_e <= r_e;
            r_m <= r_m;
        end
    end

    // Result register: captured at done, then shifted out MSB byte first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result <= {W{1'b0}};
        end else if (r_state == S_WAIT && w_done) begin
            r_result <= me_A1;
        end else if (w_out_fire) begin
            r_result <= {r_result[W-9:0], 8'h00};
        end else begin
            r_result <= r_result;
        end
    end

endmodule

// File: tb/tb_rsa_host_if.sv
// Self-checking bench for rsa_host_if. Inputs are driven and outputs are
// sampled on the falling clock edge. Expected result bytes are pushed to a
// queue when the exponentiator model presents its result and popped as the
// DUT delivers them.
module tb_rsa_host_if;

    localparam int NBYTES = 32;
    localparam int W      = 8 * NBYTES;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [7:0]     in_data;
    logic           in_ready;
    logic           key_keep;
    logic           out_valid;
    logic [7:0]     out_data;
    logic           out_ready;
    logic           me_start;
    logic [W-1:0]   me_N;
    logic [W-1:0]   me_e;
    logic [W-1:0]   me_M;
    logic           me_ready;
    logic [W-1:0]   me_A1;
    logic           busy;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    logic [W-1:0] n1, e1, m1, m2, n3, e3, m3;

    rsa_host_if #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .key_keep  (key_keep),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .me_start  (me_start),
        .me_N      (me_N),
        .me_e      (me_e),
        .me_M      (me_M),
        .me_ready  (me_ready),
        .me_A1     (me_A1),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        v = {W{1'b0}};
        for (int i = 0; i < W / 32; i++) begin
            v = {v[W-33:0], 32'($urandom())};
        end
        return v;
    endfunction

    // One byte offered for one cycle; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL load_in_ready got=%b exp=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_operand(input logic [W-1:0] v, input bit gaps);
        for (int i = 0; i < NBYTES; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom());
                    @(negedge clk);
                end
            end
            send_byte(v[W-1-8*i -: 8]);
        end
    endtask

    // Exponentiator model: idle-high ready for 3 cycles after start, low for
    // low_cycles, then high with the result.
    task automatic run_me(input logic [W-1:0] res, input int low_cycles);
        int g = 0;
        while (me_start !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        total++;
        if (me_start !== 1'b1) begin
            bad++;
            $display("FAIL me_start_seen got=%b exp=1", me_start);
        end
        me_ready = 1'b1;
        me_A1    = {W{1'b1}};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || me_start !== 1'b0) begin
                bad++;
                $display("FAIL early_ready cyc=%0d out_valid=%b me_start=%b exp=0,0", i, out_valid, me_start);
            end
        end
        me_ready = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (low_cycles) @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL wait_low out_valid=%b in_ready=%b exp=0,0", out_valid, in_ready);
        end
        me_ready = 1'b1;
        me_A1    = res;
        for (int i = 0; i < NBYTES; i++) begin
            exp_q.push_back(res[W-1-8*i -: 8]);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL capture_latency out_valid got=%b exp=1", out_valid);
        end
        me_A1 = {W{1'b1}};
    endtask

    // Take 'take' result bytes, stalling stall_len cycles when byte stall_at is shown.
    task automatic receive_result(input int take, input int stall_at, input int stall_len, input logic keep);
        int got = 0;
        int guard = 0;
        logic [7:0] eb;
        while (got < take && guard < 2000) begin
            guard++;
            if (out_valid !== 1'b1) begin
                out_ready = 1'b0;
                @(negedge clk);
            end else begin
                eb = (exp_q.size() > 0) ? exp_q[0] : 8'hxx;
                if (got == stall_at) begin
                    for (int s = 0; s < stall_len; s++) begin
                        out_ready = 1'b0;
                        key_keep  = 1'b0;
                        @(negedge clk);
                        total++;
                        if (out_valid !== 1'b1 || out_data !== eb) begin
                            bad++;
                            $display("FAIL stall_hold cyc=%0d valid=%b data=%h exp=1,%h", s, out_valid, out_data, eb);
                        end
                    end
                end
                total++;
                if (out_data !== eb) begin
                    bad++;
                    $display("FAIL result_byte idx=%0d got=%h exp=%h", got, out_data, eb);
                end
                out_ready = 1'b1;
                key_keep  = (got == NBYTES - 1) ? keep : 1'b0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                got++;
                @(negedge clk);
            end
        end
        out_ready = 1'b0;
        key_keep  = 1'b0;
        total++;
        if (guard >= 2000) begin
            bad++;
            $display("FAIL receive_timeout got=%0d exp=%0d", got, take);
        end
        if (take == NBYTES) begin
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== keep || exp_q.size() != 0) begin
                bad++;
                $display("FAIL job_end out_valid=%b in_ready=%b busy=%b left=%0d exp=0,1,%b,0",
                         out_valid, in_ready, busy, exp_q.size(), keep);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({in_ready, out_valid, out_data, me_start, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs got=%b_%b_%h_%b_%b exp=1_0_00_0_0", in_ready, out_valid, out_data, me_start, busy);
        end
        total++;
        if ({me_N, me_e, me_M} !== {(3*W){1'b0}}) begin
            bad++;
            $display("FAIL reset_operands N=%h e=%h M=%h exp=0", me_N, me_e, me_M);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load();
        load_operand(n1, 1'b0);
        load_operand(e1, 1'b0);
        load_operand(m1, 1'b0);
        total++;
        if (me_N !== n1 || me_e !== e1 || me_M !== m1) begin
            bad++;
            $display("FAIL load_values N=%h e=%h M=%h", me_N, me_e, me_M);
        end
        total++;
        if (me_start !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL load_start me_start=%b in_ready=%b busy=%b exp=1,0,1", me_start, in_ready, busy);
        end
    endtask

    task automatic test_early_ready();
        logic [W-1:0] res;
        res = {{(W-16){1'b0}}, 16'h0123};
        run_me(res, 200);
        total++;
        if (out_data !== 8'h00 || me_M !== m1) begin
            bad++;
            $display("FAIL capture_first got=%h M=%h exp=00 M=%h", out_data, me_M, m1);
        end
    endtask

    task automatic test_backpressure();
        receive_result(NBYTES, 30, 5, 1'b1);
    endtask

    task automatic test_key_keep();
        logic [W-1:0] res;
        load_operand(m2, 1'b0);
        total++;
        if (me_N !== n1 || me_e !== e1 || me_M !== m2) begin
            bad++;
            $display("FAIL keep_values N=%h e=%h M=%h", me_N, me_e, me_M);
        end
        res = rand_w();
        run_me(res, 20);
        receive_result(NBYTES, NBYTES, 0, 1'b0);
    endtask

    task automatic test_reset_mid_send();
        logic [W-1:0] res;
        load_operand(rand_w(), 1'b0);
        load_operand(rand_w(), 1'b0);
        load_operand(rand_w(), 1'b0);
        res = rand_w();
        run_me(res, 10);
        receive_result(10, NBYTES, 0, 1'b0);
        rst = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, out_data, me_start, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL send_reset_async got=%b_%b_%h_%b_%b exp=1_0_00_0_0", in_ready, out_valid, out_data, me_start, busy);
        end
        repeat (2) @(negedge clk);
        total++;
        if ({me_N, me_e, me_M} !== {(3*W){1'b0}} || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL send_reset_regs N=%h e=%h M=%h out_valid=%b", me_N, me_e, me_M, out_valid);
        end
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_gap();
        int g = 0;
        load_operand(n3, 1'b1);
        load_operand(e3, 1'b1);
        load_operand(m3, 1'b1);
        total++;
        if (me_N !== n3 || me_e !== e3 || me_M !== m3) begin
            bad++;
            $display("FAIL gap_values N=%h e=%h M=%h", me_N, me_e, me_M);
        end
        while (me_start !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        me_ready = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            total++;
            if ({in_ready, out_valid, out_data, me_start, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL wait_reset got=%b_%b_%h_%b_%b exp=1_0_00_0_0", in_ready, out_valid, out_data, me_start, busy);
            end
        end
        me_ready = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL wait_reset_after cyc=%0d out_valid=%b in_ready=%b busy=%b exp=0,1,0", i, out_valid, in_ready, busy);
            end
        end
        // The first bytes after reset must go to N.
        load_operand(n1, 1'b0);
        total++;
        if (me_N !== n1 || me_e !== {W{1'b0}} || busy !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_N N=%h e=%h busy=%b exp N=%h", me_N, me_e, busy, n1);
        end
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        key_keep  = 1'b0;
        out_ready = 1'b0;
        me_ready  = 1'b1;
        me_A1     = {W{1'b0}};
        n1 = {{(W-8){1'b0}}, 8'hF1};
        e1 = {{(W-8){1'b0}}, 8'h11};
        m1 = {{(W-8){1'b0}}, 8'h41};
        m2 = rand_w();
        n3 = rand_w();
        e3 = rand_w();
        m3 = rand_w();
        @(negedge clk);
        test_reset();
        test_load();
        test_early_ready();
        test_backpressure();
        test_key_keep();
        test_reset_mid_send();
        test_gap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
